// File: rtl/tdm_mux_8way_pkg.sv
// Shared definitions for the 8-way TDM transmitter: FSM states, link
// geometry and the slot-to-channel mapping.
package tdm_mux_8way_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int HOLD_W    = 4;

    // Slot code k carries channel 7-k, matching the far-end demux decode.
    function automatic logic [SLOT_W-1:0] chan_of_slot(input logic [SLOT_W-1:0] slot);
        return SLOT_W'(NUM_SLOTS - 1) - slot;
    endfunction

endpackage

// File: rtl/tdm_mux_8way_slot_timer.sv
// Slot timer: holds each slot for SLOT_CYCLES clocks and steps the 3-bit
// slot code, wrapping 111 -> 000. load restarts a frame at slot 000.
module slot_timer
    import tdm_mux_8way_pkg::*;
#(
    parameter int SLOT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load,
    output logic [SLOT_W-1:0] slot,
    output logic              slot_end,
    output logic              frame_end
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    assign slot      = slot_q;
    assign slot_end  = run && (hold_q == HOLD_LAST);
    assign frame_end = slot_end && (slot_q == SLOT_LAST);

    // Next-state: load wins over counting so a frame restart is always clean.
    always_comb begin
        hold_d = hold_q;
        slot_d = slot_q;
        if (load) begin
            hold_d = '0;
            slot_d = '0;
        end else if (slot_end) begin
            hold_d = '0;
            slot_d = slot_q + SLOT_W'(1);
        end else if (run) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Counter registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            slot_q <= '0;
        end else begin
            hold_q <= hold_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tdm_mux_8way.sv
// 8-way TDM transmitter: snapshots eight channels on enable and serialises
// them one per slot with a 3-bit select code for a far-end 8-way demux.
// All outputs come from registered state only.
module tdm_mux_8way
    import tdm_mux_8way_pkg::*;
#(
    parameter int SLOT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in7,
    input  logic in6,
    input  logic in5,
    input  logic in4,
    input  logic in3,
    input  logic in2,
    input  logic in1,
    input  logic in0,
    output logic i0,
    output logic s2,
    output logic s1,
    output logic s0,
    output logic valid,
    output logic frame_start,
    output logic busy
);

    state_e            state_q, state_d;
    logic [7:0]        frame_q;
    logic              slot_first_q;
    logic              load;
    logic              run;
    logic [SLOT_W-1:0] slot;
    logic              slot_end;
    logic              frame_end;

    slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .load     (load),
        .slot     (slot),
        .slot_end (slot_end),
        .frame_end(frame_end)
    );

    // FSM next state: en only matters in IDLE or on the last cycle of a frame.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
                if (frame_end) begin
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame snapshot (bit 7 = in7) and first-cycle-of-slot flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q      <= '0;
            slot_first_q <= 1'b0;
        end else begin
            if (load) begin
                frame_q <= {in7, in6, in5, in4, in3, in2, in1, in0};
            end
            slot_first_q <= load | slot_end;
        end
    end

    // Output select; an idle link drives everything low.
    assign busy        = (state_q == ST_RUN);
    assign valid       = busy;
    assign {s2, s1, s0} = slot;
    assign frame_start = busy && slot_first_q && (slot == '0);
    assign i0          = busy && frame_q[chan_of_slot(slot)];

endmodule

// File: tb/tb_tdm_mux_8way.sv
// Directed bench for tdm_mux_8way: two instances (1 and 3 cycles per slot),
// scoreboard queues filled when stimulus is driven, popped every sample.
module tb_tdm_mux_8way;

    typedef struct packed {
        logic       valid;
        logic       busy;
        logic       fs;
        logic [2:0] s;
        logic       i0;
        logic [7:0] dmx;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       en1, en3;
    logic [7:0] in1, in3;
    logic       i0_1, s2_1, s1_1, s0_1, valid_1, fs_1, busy_1;
    logic       i0_3, s2_3, s1_3, s0_3, valid_3, fs_3, busy_3;
    logic [7:0] dmx1, dmx3;

    exp_t q1[$];
    exp_t q3[$];

    int compared   = 0;
    int mismatched = 0;

    tdm_mux_8way #(.SLOT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1),
        .in7(in1[7]), .in6(in1[6]), .in5(in1[5]), .in4(in1[4]),
        .in3(in1[3]), .in2(in1[2]), .in1(in1[1]), .in0(in1[0]),
        .i0(i0_1), .s2(s2_1), .s1(s1_1), .s0(s0_1),
        .valid(valid_1), .frame_start(fs_1), .busy(busy_1)
    );

    tdm_mux_8way #(.SLOT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3),
        .in7(in3[7]), .in6(in3[6]), .in5(in3[5]), .in4(in3[4]),
        .in3(in3[3]), .in2(in3[2]), .in1(in3[1]), .in0(in3[0]),
        .i0(i0_3), .s2(s2_3), .s1(s1_3), .s0(s0_3),
        .valid(valid_3), .frame_start(fs_3), .busy(busy_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Far-end 8-way demux model: output k follows i0 when the code is k.
    always_comb begin
        dmx1 = '0;
        dmx3 = '0;
        for (int k = 0; k < 8; k++) begin
            dmx1[k] = i0_1 && ({s2_1, s1_1, s0_1} == 3'(k));
            dmx3[k] = i0_3 && ({s2_3, s1_3, s0_3} == 3'(k));
        end
    end

    function automatic exp_t mk(input logic v, input logic [2:0] s,
                                input logic b, input logic fs);
        exp_t e;
        e.valid = v;
        e.busy  = v;
        e.fs    = fs;
        e.s     = s;
        e.i0    = v && b;
        e.dmx   = (v && b) ? (8'b1 << s) : 8'b0;
        return e;
    endfunction

    function automatic exp_t obs1();
        exp_t o;
        o = {valid_1, busy_1, fs_1, s2_1, s1_1, s0_1, i0_1, dmx1};
        return o;
    endfunction

    function automatic exp_t obs3();
        exp_t o;
        o = {valid_3, busy_3, fs_3, s2_3, s1_3, s0_3, i0_3, dmx3};
        return o;
    endfunction

    task automatic check(input string tag, input exp_t got, input exp_t exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h (v,b,fs,s,i0,dmx)", tag, got, exp);
        end
    endtask

    // Queue the expected samples of one full frame of bits (bit 7 = in7).
    task automatic push_frame(input int which, input logic [7:0] bits, input int sc);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < sc; h++) begin
                e = mk(1'b1, 3'(k), bits[7-k], (k == 0) && (h == 0));
                if (which == 1) q1.push_back(e);
                else            q3.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 1) q1.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0));
            else            q3.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0));
        end
    endtask

    // One sample point per cycle, on the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1", obs1(), e);
            $display("t=%0t dut1 v=%b fs=%b s=%0d i0=%b dmx=%b", $time,
                     valid_1, fs_1, {s2_1, s1_1, s0_1}, i0_1, dmx1);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("dut3", obs3(), e);
            $display("t=%0t dut3 v=%b fs=%b s=%0d i0=%b", $time,
                     valid_3, fs_3, {s2_3, s1_3, s0_3}, i0_3);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en1 = 1'b0; en3 = 1'b0;
        in1 = '0;   in3 = '0;
        #1;

        // Reset held with en high and all inputs high: link stays silent.
        rst_n = 1'b0;
        en1 = 1'b1; en3 = 1'b1;
        in1 = 8'hFF; in3 = 8'hFF;
        push_idle(1, 3);
        push_idle(3, 3);
        repeat (3) tick();
        rst_n = 1'b0;
        en1 = 1'b0; en3 = 1'b0;
        rst_n = 1'b1;
        push_idle(1, 1);
        push_idle(3, 1);
        tick();

        // Single frame, one cycle per slot: in7..in0 = 1,0,1,1,0,0,1,0.
        push_frame(1, 8'hB2, 1);
        push_idle(1, 2);
        en1 = 1'b1; in1 = 8'hB2;
        tick();
        en1 = 1'b0; in1 = 8'h00;
        repeat (9) tick();

        // Back-to-back frames A5 then 3C with en held high.
        push_frame(1, 8'hA5, 1);
        push_frame(1, 8'h3C, 1);
        push_idle(1, 1);
        en1 = 1'b1; in1 = 8'hA5;
        tick();
        in1 = 8'h3C;
        repeat (7) tick();
        tick();
        en1 = 1'b0; in1 = 8'h00;
        repeat (8) tick();

        // Three cycles per slot; inputs change and en drops during slot 010.
        push_frame(3, 8'hC9, 3);
        push_idle(3, 1);
        en3 = 1'b1; in3 = 8'hC9;
        repeat (7) tick();
        en3 = 1'b0; in3 = 8'h36;
        repeat (18) tick();

        // Reset asserted mid-frame at slot 101: outputs clear before any edge.
        for (int k = 0; k < 6; k++) begin
            q1.push_back(mk(1'b1, 3'(k), 1'b1, k == 0));
        end
        en1 = 1'b1; in1 = 8'hFF;
        tick();
        en1 = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dut1", obs1(), mk(1'b0, 3'd0, 1'b0, 1'b0));
        check("async_rst_dut3", obs3(), mk(1'b0, 3'd0, 1'b0, 1'b0));
        $display("t=%0t async reset: v=%b s=%0d i0=%b", $time,
                 valid_1, {s2_1, s1_1, s0_1}, i0_1);
        tick();
        rst_n = 1'b1;

        // Clean restart after reset.
        push_idle(1, 1);
        tick();
        push_frame(1, 8'h5A, 1);
        push_idle(1, 1);
        en1 = 1'b1; in1 = 8'h5A;
        tick();
        en1 = 1'b0;
        repeat (8) tick();

        compared++;
        assert ((q1.size() + q3.size()) == 0) else begin
            mismatched++;
            $error("FAIL queue_drain observed=%0d expected=0", q1.size() + q3.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
